// File: rtl/pattern_serializer.sv
// Parallel-to-serial pattern source: shifts a loaded pattern out MSB-first,
// repeating it a programmable number of times with optional zero-gap runs.
`timescale 1ns/1ps

module pattern_serializer #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_count,
    input  logic [GAP_W-1:0] gap_len,
    input  logic             abort,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [CNT_W-1:0]   rep_q, rep_d;
    logic [GAP_W-1:0]   gap_len_q, gap_len_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               done_d;
    logic               out_d;
    logic               out_valid_d;
    logic               busy_d;
    logic               load_fire;

    assign load_ready = (state_q == IDLE) && rst;
    // abort outranks a simultaneous load request
    assign load_fire  = load_valid && load_ready && !abort;

    // State and working registers; outputs are registered from next-state values
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            rep_q     <= '0;
            gap_len_q <= '0;
            gap_cnt_q <= '0;
            idx_q     <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            rep_q     <= rep_d;
            gap_len_q <= gap_len_d;
            gap_cnt_q <= gap_cnt_d;
            idx_q     <= idx_d;
            out       <= out_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        rep_d     = rep_q;
        gap_len_d = gap_len_q;
        gap_cnt_d = gap_cnt_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_fire) begin
                    pat_d     = pattern;
                    rep_d     = repeat_count;
                    gap_len_d = gap_len;
                    gap_cnt_d = '0;
                    idx_d     = IDX_MSB;
                    if (repeat_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (idx_q != '0) begin
                    idx_d = idx_q - 1'b1;
                end else begin
                    // end of one repetition: compare before decrement so max counts never wrap
                    rep_d = rep_q - 1'b1;
                    if (rep_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (gap_len_q != '0) begin
                        state_d   = GAP;
                        gap_cnt_d = gap_len_q - 1'b1;
                    end else begin
                        idx_d = IDX_MSB;
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (gap_cnt_q == '0) begin
                    state_d = SHIFT;
                    idx_d   = IDX_MSB;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_d       = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        case (state_d)
            SHIFT: begin
                out_d       = pat_d[idx_d];
                out_valid_d = 1'b1;
                busy_d      = 1'b1;
            end
            GAP: begin
                out_valid_d = 1'b1;
                busy_d      = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
